// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - fully-connected layer sequencer: input broadcast, result capture, ordered drain
module layer_sequencer #(
    parameter int numNeuron = 30,
    parameter int numWeight = 784,
    parameter int dataWidth = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [dataWidth-1:0]           in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [dataWidth-1:0]           neuron_in,
    output logic                           neuron_in_valid,
    input  logic [numNeuron*dataWidth-1:0] neuron_out,
    input  logic [numNeuron-1:0]           neuron_out_valid,
    output logic [dataWidth-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           layer_done
);

    localparam int CNT_W = $clog2(numWeight + 1);
    localparam int IDX_W = (numNeuron > 1) ? $clog2(numNeuron) : 1;
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(numWeight - 1);
    localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(numNeuron - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     in_cnt;
    logic [IDX_W-1:0]     out_idx;
    logic [numNeuron-1:0] flag;
    logic [numNeuron-1:0] cap_en;
    logic [numNeuron-1:0] flag_next;
    logic [dataWidth-1:0] cap [numNeuron];
    logic                 accept;
    logic                 xfer;

    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    // Only the first outvalid of each neuron per pass is kept.
    assign cap_en    = (state != S_IDLE) ? (neuron_out_valid & ~flag) : '0;
    assign flag_next = flag | cap_en;

    always_comb begin
        in_ready  = (state == S_FEED);
        out_valid = (state == S_DRAIN);
        out_data  = '0;
        if (state == S_DRAIN) begin
            out_data = cap[out_idx];
        end
        busy = (state == S_WAIT) || (state == S_DRAIN) ||
               ((state == S_FEED) && (in_cnt != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            in_cnt          <= '0;
            out_idx         <= '0;
            flag            <= '0;
            neuron_in       <= '0;
            neuron_in_valid <= 1'b0;
            layer_done      <= 1'b0;
            for (int k = 0; k < numNeuron; k++) begin
                cap[k] <= '0;
            end
        end else begin
            neuron_in_valid <= accept;
            layer_done      <= 1'b0;
            if (accept) begin
                neuron_in <= in_data;
            end
            for (int k = 0; k < numNeuron; k++) begin
                if (cap_en[k]) begin
                    cap[k] <= neuron_out[k*dataWidth +: dataWidth];
                end
            end

            case (state)
                S_IDLE: begin
                    in_cnt  <= '0;
                    out_idx <= '0;
                    flag    <= '0;
                    state   <= S_FEED;
                end
                S_FEED: begin
                    flag <= flag_next;
                    if (accept) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == LAST_IN) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    flag <= flag_next;
                    // Captures landing on this edge count, so no idle cycle before draining.
                    if (&flag_next) begin
                        state <= S_DRAIN;
                    end
                end
                default: begin
                    flag <= flag_next;
                    if (xfer) begin
                        out_idx <= out_idx + 1'b1;
                        if (out_idx == LAST_OUT) begin
                            state      <= S_IDLE;
                            layer_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - table-driven bench for layer_sequencer with 3 neurons and 4 weights
module tb_layer_sequencer;

    localparam int NN = 3;
    localparam int NW = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     neuron_in;
    logic              neuron_in_valid;
    logic [NN*DW-1:0]  neuron_out = '0;
    logic [NN-1:0]     neuron_out_valid = '0;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              layer_done;

    int checks = 0;
    int errors = 0;

    layer_sequencer #(.numNeuron(NN), .numWeight(NW), .dataWidth(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .neuron_in        (neuron_in),
        .neuron_in_valid  (neuron_in_valid),
        .neuron_out       (neuron_out),
        .neuron_out_valid (neuron_out_valid),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy),
        .layer_done       (layer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          iv;
        logic [15:0]   id;
        logic [2:0]    nov;
        logic [47:0]   no;
        logic          rdy;
        logic          e_ir;
        logic          e_niv;
        logic [15:0]   e_ni;
        logic          e_ov;
        logic [15:0]   e_od;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic iv, input logic [15:0] id,
                       input logic [2:0] nov, input logic [47:0] no, input logic rdy,
                       input logic ir, input logic niv, input logic [15:0] ni,
                       input logic ov, input logic [15:0] od, input logic bz, input logic dn);
        vec_t v;
        v.rst = r; v.iv = iv; v.id = id; v.nov = nov; v.no = no; v.rdy = rdy;
        v.e_ir = ir; v.e_niv = niv; v.e_ni = ni; v.e_ov = ov; v.e_od = od;
        v.e_busy = bz; v.e_done = dn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic feed4(input logic [15:0] base);
        for (int i = 0; i < NW; i++) begin
            int g = 0;
            in_valid = 1'b1;
            in_data  = base + 16'(i);
            while (!in_ready && g < 20) begin
                @(negedge clk); #1;
                g++;
            end
            chk("feed_timeout", 48'(g < 20), 48'd1);
            @(negedge clk); #1;
            chk($sformatf("feed_niv[%0d]", i), 48'(neuron_in_valid), 48'd1);
            chk($sformatf("feed_ni[%0d]", i), 48'(neuron_in), 48'(base + 16'(i)));
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic drain3(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        logic [15:0] exp_q [3];
        exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2;
        out_ready = 1'b1;
        for (int k = 0; k < NN; k++) begin
            int g = 0;
            while (!out_valid && g < 20) begin
                @(negedge clk); #1;
                g++;
            end
            chk("drain_timeout", 48'(g < 20), 48'd1);
            chk($sformatf("drain_data[%0d]", k), 48'(out_data), 48'(exp_q[k]));
            @(negedge clk); #1;
        end
        out_ready = 1'b0;
        chk("drain_done_pulse", 48'(layer_done), 48'd1);
        chk("drain_ov_drop", 48'(out_valid), 48'd0);
        @(negedge clk); #1;
        chk("drain_done_clear", 48'(layer_done), 48'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   rst iv data      nov     neuron_out                         rdy | ir niv ni       ov od       bz dn
        add(1, 0, 16'h0000, 3'b000, 48'h0,                             0,   0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        add(1, 0, 16'h0000, 3'b000, 48'h0,                             0,   0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             0,   0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        add(0, 1, 16'h0100, 3'b000, 48'h0,                             0,   1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        add(0, 1, 16'h0200, 3'b000, 48'h0,                             0,   1, 1, 16'h0100, 0, 16'h0000, 1, 0);
        add(0, 1, 16'h0300, 3'b000, 48'h0,                             0,   1, 1, 16'h0200, 0, 16'h0000, 1, 0);
        add(0, 1, 16'h0400, 3'b000, 48'h0,                             0,   1, 1, 16'h0300, 0, 16'h0000, 1, 0);
        add(0, 1, 16'h0500, 3'b000, 48'h0,                             0,   0, 1, 16'h0400, 0, 16'h0000, 1, 0);
        add(0, 1, 16'h0600, 3'b101, {16'h0033, 16'hAAAA, 16'h0011},    0,   0, 0, 16'h0400, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             0,   0, 0, 16'h0400, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h0000, 3'b010, {16'h0000, 16'h0022, 16'h0000},    0,   0, 0, 16'h0400, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h0000, 3'b001, {16'h0000, 16'h0000, 16'hFFFF},    0,   0, 0, 16'h0400, 1, 16'h0011, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             1,   0, 0, 16'h0400, 1, 16'h0011, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             0,   0, 0, 16'h0400, 1, 16'h0022, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             0,   0, 0, 16'h0400, 1, 16'h0022, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             1,   0, 0, 16'h0400, 1, 16'h0022, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             1,   0, 0, 16'h0400, 1, 16'h0033, 1, 0);
        add(0, 0, 16'h0000, 3'b111, {16'h7777, 16'h7777, 16'h7777},    0,   0, 0, 16'h0400, 0, 16'h0000, 0, 1);
        add(0, 1, 16'h1111, 3'b000, 48'h0,                             0,   1, 0, 16'h0400, 0, 16'h0000, 0, 0);
        add(0, 0, 16'h9999, 3'b000, 48'h0,                             0,   1, 1, 16'h1111, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h9999, 3'b000, 48'h0,                             0,   1, 0, 16'h1111, 0, 16'h0000, 1, 0);
        add(0, 1, 16'h2222, 3'b000, 48'h0,                             0,   1, 0, 16'h1111, 0, 16'h0000, 1, 0);
        add(0, 1, 16'h3333, 3'b000, 48'h0,                             0,   1, 1, 16'h2222, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h9999, 3'b000, 48'h0,                             0,   1, 1, 16'h3333, 0, 16'h0000, 1, 0);
        add(0, 1, 16'h4444, 3'b000, 48'h0,                             0,   1, 0, 16'h3333, 0, 16'h0000, 1, 0);
        add(0, 1, 16'h5555, 3'b111, {16'h0C0C, 16'h0B0B, 16'h0A0A},    0,   0, 1, 16'h4444, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             1,   0, 0, 16'h4444, 1, 16'h0A0A, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             1,   0, 0, 16'h4444, 1, 16'h0B0B, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             1,   0, 0, 16'h4444, 1, 16'h0C0C, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             0,   0, 0, 16'h4444, 0, 16'h0000, 0, 1);
        add(0, 1, 16'h5151, 3'b011, {16'h0000, 16'hBEEF, 16'hDEAD},    0,   1, 0, 16'h4444, 0, 16'h0000, 0, 0);
        add(0, 1, 16'h5252, 3'b000, 48'h0,                             0,   1, 1, 16'h5151, 0, 16'h0000, 1, 0);
        add(1, 0, 16'h0000, 3'b000, 48'h0,                             0,   1, 1, 16'h5252, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             0,   0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        add(0, 1, 16'h0001, 3'b100, {16'h0303, 16'h0000, 16'h0000},    0,   1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        add(0, 1, 16'h0002, 3'b000, 48'h0,                             0,   1, 1, 16'h0001, 0, 16'h0000, 1, 0);
        add(0, 1, 16'h0003, 3'b000, 48'h0,                             0,   1, 1, 16'h0002, 0, 16'h0000, 1, 0);
        add(0, 1, 16'h0004, 3'b000, 48'h0,                             0,   1, 1, 16'h0003, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             0,   0, 1, 16'h0004, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             0,   0, 0, 16'h0004, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h0000, 3'b011, {16'h0000, 16'h0202, 16'h0101},    0,   0, 0, 16'h0004, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             1,   0, 0, 16'h0004, 1, 16'h0101, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             1,   0, 0, 16'h0004, 1, 16'h0202, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             1,   0, 0, 16'h0004, 1, 16'h0303, 1, 0);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             0,   0, 0, 16'h0004, 0, 16'h0000, 0, 1);
        add(0, 0, 16'h0000, 3'b000, 48'h0,                             0,   1, 0, 16'h0004, 0, 16'h0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst              = vecs[i].rst;
            in_valid         = vecs[i].iv;
            in_data          = vecs[i].id;
            neuron_out_valid = vecs[i].nov;
            neuron_out       = vecs[i].no;
            out_ready        = vecs[i].rdy;
            #1;
            chk($sformatf("row%0d in_ready", i),        48'(in_ready),        48'(vecs[i].e_ir));
            chk($sformatf("row%0d neuron_in_valid", i), 48'(neuron_in_valid), 48'(vecs[i].e_niv));
            chk($sformatf("row%0d neuron_in", i),       48'(neuron_in),       48'(vecs[i].e_ni));
            chk($sformatf("row%0d out_valid", i),       48'(out_valid),       48'(vecs[i].e_ov));
            chk($sformatf("row%0d out_data", i),        48'(out_data),        48'(vecs[i].e_od));
            chk($sformatf("row%0d busy", i),            48'(busy),            48'(vecs[i].e_busy));
            chk($sformatf("row%0d layer_done", i),      48'(layer_done),      48'(vecs[i].e_done));
        end
        in_valid = 1'b0;
        neuron_out_valid = '0;
        neuron_out = '0;
        out_ready = 1'b0;

        // Reset in the middle of a drain, after one result has left.
        feed4(16'h2000);
        neuron_out_valid = 3'b111;
        neuron_out = {16'h3003, 16'h3002, 16'h3001};
        @(negedge clk); #1;
        neuron_out_valid = '0;
        neuron_out = '0;
        out_ready = 1'b1;
        chk("mid_drain_ov", 48'(out_valid), 48'd1);
        chk("mid_drain_d0", 48'(out_data), 48'h3001);
        @(negedge clk); #1;
        chk("mid_drain_d1", 48'(out_data), 48'h3002);
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        chk("post_rst_ov", 48'(out_valid), 48'd0);
        chk("post_rst_od", 48'(out_data), 48'd0);
        chk("post_rst_busy", 48'(busy), 48'd0);
        chk("post_rst_ir", 48'(in_ready), 48'd0);
        chk("post_rst_ni", 48'(neuron_in), 48'd0);
        chk("post_rst_done", 48'(layer_done), 48'd0);

        // Fresh pass; drain must wait until the late neuron reports.
        feed4(16'h4000);
        neuron_out_valid = 3'b011;
        neuron_out = {16'h0000, 16'h5002, 16'h5001};
        @(negedge clk); #1;
        neuron_out_valid = '0;
        neuron_out = '0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("partial_wait_ov[%0d]", c), 48'(out_valid), 48'd0);
            chk($sformatf("partial_wait_busy[%0d]", c), 48'(busy), 48'd1);
            @(negedge clk); #1;
        end
        neuron_out_valid = 3'b100;
        neuron_out = {16'h5003, 16'h0000, 16'h0000};
        @(negedge clk); #1;
        neuron_out_valid = '0;
        neuron_out = '0;
        chk("late_capture_drain", 48'(out_valid), 48'd1);
        drain3(16'h5001, 16'h5002, 16'h5003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
